// File: rtl/spi_mon_pkg.sv
// Shared types and constants for the SPI RAM link frame monitor.
//   spi_cmd_e        : 2-bit frame command, sent MSB first on MOSI
//   spi_mon_state_e  : frame tracking state of spi_frame_monitor
//   CMD_W            : command field width in bits
package spi_mon_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_cmd_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        PAYLOAD  = 3'd2,
        TURN     = 3'd3,
        RDBACK   = 3'd4,
        END      = 3'd5,
        WAIT_END = 3'd6
    } spi_mon_state_e;

endpackage

// File: rtl/spi_mon_shift.sv
// Serial-in shift register with a bit down-counter.
//   clk, rst : clock and synchronous active-high reset
//   clr      : reload the bit counter for a new field
//   en       : shift din in (MSB first) this edge
//   data     : shifted-in field
//   done     : high during the edge that shifts in the last of DATA_W bits
module spi_mon_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [DATA_W-1:0] data,
    output logic              done
);

    localparam int BCW = $clog2(DATA_W + 1);
    localparam logic [BCW-1:0] LOAD = BCW'(DATA_W - 1);

    logic [BCW-1:0] bit_cnt;

    assign done = en && (bit_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            bit_cnt <= LOAD;
        end else if (clr) begin
            bit_cnt <= LOAD;
        end else if (en) begin
            data    <= {data[DATA_W-2:0], din};
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spi_frame_monitor.sv
// Passive monitor for the SPI RAM slave link: decodes command + payload,
// captures read-back data, checks frame length and address/data ordering.
//   clk, rst              : clock, synchronous active-high reset
//   SS_n, MOSI, MISO      : observed SPI lines (one bit per clk edge)
//   err_clr               : clears the sticky error flags
//   frame_valid/cmd/payload, rd_data/rd_data_valid : completed good frame
//   err_short/long/order  : sticky error flags
//   cnt_wr/cnt_rd/cnt_err : saturating frame counters
//
// state    | meaning
// IDLE     | waiting for SS_n low (armed); samples cmd MSB
// CMD      | samples cmd LSB
// PAYLOAD  | shifting DATA_W MOSI payload bits
// TURN     | TURN_CYC dummy cycles before read-back (RD_DATA only)
// RDBACK   | shifting DATA_W MISO bits (RD_DATA only)
// END      | expected length reached; SS_n must be high now
// WAIT_END | over-long frame, waiting for SS_n high
module spi_frame_monitor
    import spi_mon_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int TURN_CYC     = 1,
    parameter int CNT_W        = 16,
    parameter int STRICT_ORDER = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              MISO,
    input  logic              err_clr,
    output logic              frame_valid,
    output logic [CMD_W-1:0]  frame_cmd,
    output logic [DATA_W-1:0] frame_payload,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              err_short,
    output logic              err_long,
    output logic              err_order,
    output logic [CNT_W-1:0]  cnt_wr,
    output logic [CNT_W-1:0]  cnt_rd,
    output logic [CNT_W-1:0]  cnt_err
);

    localparam logic [1:0] TURN_LOAD = (TURN_CYC > 0) ? 2'(TURN_CYC - 1) : 2'd0;

    spi_mon_state_e    state, state_d;
    logic              armed, pending_wr, pending_rd;
    logic [CMD_W-1:0]  cmd_q;
    logic [1:0]        turn_cnt;
    logic [DATA_W-1:0] mosi_data, miso_data;
    logic              mosi_done, miso_done;
    logic              set_short, set_long, frame_done, order_err, is_rd_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    spi_mon_shift #(.DATA_W(DATA_W)) u_mosi (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .en   ((state == PAYLOAD) && !SS_n),
        .din  (MOSI),
        .data (mosi_data),
        .done (mosi_done)
    );

    spi_mon_shift #(.DATA_W(DATA_W)) u_miso (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .en   ((state == RDBACK) && !SS_n),
        .din  (MISO),
        .data (miso_data),
        .done (miso_done)
    );

    assign is_rd_data = (cmd_q == RD_DATA);
    assign order_err  = frame_done && (STRICT_ORDER != 0) &&
                        (((cmd_q == WR_DATA) && !pending_wr) || (is_rd_data && !pending_rd));

    always_comb begin
        state_d    = state;
        set_short  = 1'b0;
        set_long   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: if (armed && !SS_n) state_d = CMD;
            CMD: begin
                if (SS_n) begin
                    set_short = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (SS_n) begin
                    set_short = 1'b1;
                    state_d   = IDLE;
                end else if (mosi_done) begin
                    if (!is_rd_data)        state_d = END;
                    else if (TURN_CYC == 0) state_d = RDBACK;
                    else                    state_d = TURN;
                end
            end
            TURN: begin
                if (SS_n) begin
                    set_short = 1'b1;
                    state_d   = IDLE;
                end else if (turn_cnt == 2'd0) begin
                    state_d = RDBACK;
                end
            end
            RDBACK: begin
                if (SS_n) begin
                    set_short = 1'b1;
                    state_d   = IDLE;
                end else if (miso_done) begin
                    state_d = END;
                end
            end
            END: begin
                if (SS_n) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end else begin
                    set_long = 1'b1;
                    state_d  = WAIT_END;
                end
            end
            WAIT_END: if (SS_n) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            armed         <= 1'b0;
            pending_wr    <= 1'b0;
            pending_rd    <= 1'b0;
            cmd_q         <= '0;
            turn_cnt      <= 2'd0;
            frame_valid   <= 1'b0;
            frame_cmd     <= '0;
            frame_payload <= '0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            err_short     <= 1'b0;
            err_long      <= 1'b0;
            err_order     <= 1'b0;
            cnt_wr        <= '0;
            cnt_rd        <= '0;
            cnt_err       <= '0;
        end else begin
            state         <= state_d;
            frame_valid   <= frame_done;
            rd_data_valid <= frame_done && is_rd_data;
            // A reset mid-frame leaves SS_n low; only a sampled high re-arms.
            if (SS_n) armed <= 1'b1;
            if (((state == IDLE) && (state_d == CMD)) || (state == CMD))
                cmd_q <= {cmd_q[0], MOSI};
            if ((state == PAYLOAD) && (state_d == TURN))
                turn_cnt <= TURN_LOAD;
            else if (state == TURN)
                turn_cnt <= turn_cnt - 2'd1;
            if (frame_done) begin
                frame_cmd     <= cmd_q;
                frame_payload <= mosi_data;
                if (is_rd_data) rd_data <= miso_data;
                case (cmd_q)
                    WR_ADDR: pending_wr <= 1'b1;
                    WR_DATA: pending_wr <= 1'b0;
                    RD_ADDR: pending_rd <= 1'b1;
                    default: pending_rd <= 1'b0;
                endcase
                if (!order_err) begin
                    if (cmd_q[1]) cnt_rd <= sat_inc(cnt_rd);
                    else          cnt_wr <= sat_inc(cnt_wr);
                end
            end
            if (set_short || set_long || order_err) cnt_err <= sat_inc(cnt_err);
            // A new error on the same edge as err_clr survives the clear.
            err_short <= (err_short && !err_clr) || set_short;
            err_long  <= (err_long  && !err_clr) || set_long;
            err_order <= (err_order && !err_clr) || order_err;
        end
    end

endmodule

// File: doc/spi_frame_monitor.md
Name: spi_frame_monitor

Overview:
- Synthesizable, parametrised bus monitor for the SPI RAM slave link. It sits passively on SS_n/MOSI/MISO beside the SPI wrapper.
- Decodes each frame's 2-bit command and DATA_W-bit payload, and captures read-back data from MISO.
- Checks frame length and the address-before-data command ordering, and keeps sticky error flags and saturating frame counters.
- Generalises the fixed MOSI-prefix property checks into data width, turnaround and strictness knobs; it is usable in silicon debug and in the bench.

Parameters:
- DATA_W, 8: payload / read-data width in bits.
- TURN_CYC, 1: dummy cycles between the end of the RD_DATA payload and the first MISO bit (0..3).
- CNT_W, 16: width of each frame counter.
- STRICT_ORDER, 1: 1 = enable ordering checks; 0 = err_order is never set.

Ports:
- clk  in  1  system clock; all sampling on posedge.
- rst  in  1  synchronous, active-high reset.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  master-out serial data, MSB first.
- MISO  in  1  slave-out serial data, MSB first.
- err_clr  in  1  clears the sticky error flags.
- frame_valid  out  1  one-cycle pulse: a well-formed frame has completed.
- frame_cmd  out  2  command of the completed frame.
- frame_payload  out  DATA_W  MOSI payload of the completed frame.
- rd_data  out  DATA_W  MISO bits captured in an RD_DATA frame.
- rd_data_valid  out  1  pulse coincident with frame_valid when frame_cmd is RD_DATA.
- err_short  out  1  sticky: SS_n deasserted before the expected length.
- err_long  out  1  sticky: SS_n still low after the expected length.
- err_order  out  1  sticky: data command without a preceding address command.
- cnt_wr  out  CNT_W  count of good WR_ADDR + WR_DATA frames.
- cnt_rd  out  CNT_W  count of good RD_ADDR + RD_DATA frames.
- cnt_err  out  CNT_W  count of frames that set any error.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; pending_wr and pending_rd cleared; armed = 0.
- Arming after reset:
  - The monitor ignores traffic until SS_n is sampled 1 once (armed = 1). A reset mid-frame therefore never decodes a partial frame.
- Commands, MSB first:
  - 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- Bit timing:
  - Bit 0 is MOSI at the first edge where SS_n == 0 while in IDLE with armed set.
  - One bit per clk edge.
- Expected length L:
  - 2 + DATA_W for WR_ADDR, WR_DATA and RD_ADDR.
  - 2 + DATA_W + TURN_CYC + DATA_W for RD_DATA.
- FSM states:
  - IDLE: on SS_n == 0 and armed, sample cmd MSB, go to CMD.
  - CMD: sample cmd LSB, go to PAYLOAD.
  - PAYLOAD: shift MOSI for DATA_W bits. Then go to END; for RD_DATA go to TURN, or straight to RDBACK if TURN_CYC == 0.
  - TURN: count TURN_CYC cycles, go to RDBACK.
  - RDBACK: shift MISO for DATA_W bits, go to END.
  - END: if SS_n == 1, the frame is good. If SS_n == 0, set err_long and go to WAIT_END.
  - WAIT_END: wait for SS_n == 1, then go to IDLE. No frame_valid is issued.
- Short frame:
  - SS_n == 1 in any state from CMD to RDBACK sets err_short and discards the frame.
  - No frame_valid is issued; go to IDLE.
- Good-frame latency:
  - frame_valid, frame_cmd, frame_payload (and rd_data / rd_data_valid) are registered on the END edge. They are visible in the cycle after SS_n is sampled high.
  - Back-to-back frames are legal: SS_n low again on the edge immediately after END starts a new frame from IDLE.
- Ordering (STRICT_ORDER = 1):
  - WR_ADDR sets pending_wr; WR_DATA clears it. WR_DATA with pending_wr == 0 sets err_order.
  - RD_ADDR sets pending_rd; RD_DATA clears it. RD_DATA with pending_rd == 0 sets err_order.
  - A repeated address command is legal and overwrites the pending state.
  - An order-error frame is still reported through frame_valid. It counts in cnt_err, not in cnt_wr / cnt_rd.
  - Ordering state is updated only on good-length frames.
- Counters:
  - Each counter increments once per frame and saturates at all-ones.
- Sticky flags:
  - Cleared by err_clr.
  - If err_clr and a new error occur on the same edge, the error wins.
- frame_cmd and frame_payload hold their values between pulses.

Decomposition:
- Package spi_mon_pkg:
  - spi_cmd_e enum {WR_ADDR = 2'b00, WR_DATA = 2'b01, RD_ADDR = 2'b10, RD_DATA = 2'b11}.
  - spi_mon_state_e enum {IDLE, CMD, PAYLOAD, TURN, RDBACK, END, WAIT_END}.
  - Constant CMD_W = 2.
- Sub-module spi_mon_shift:
  - Parametrised DATA_W serial-in shift register with a bit counter and a done flag.
  - Instantiated twice, once for MOSI and once for MISO.

Test Plan:
- DATA_W = 8; frame WR_ADDR 0x3C then WR_DATA 0xA5, SS_n high between them -> two frame_valid pulses: cmd 00 / payload 0x3C, then cmd 01 / payload 0xA5; cnt_wr = 2; no errors.
- RD_ADDR 0x3C, then RD_DATA with MISO driving 0xA5 after 1 turnaround cycle -> rd_data_valid with rd_data = 0xA5; cnt_rd = 2.
- WR_DATA 0x11 after reset with no WR_ADDR -> frame_valid with cmd 01; err_order = 1; cnt_err = 1; cnt_wr = 0.
- SS_n raised after 6 bits of WR_ADDR -> err_short = 1; no frame_valid. Next full WR_ADDR 0x01 is decoded correctly.
- SS_n held low for 3 extra cycles after WR_ADDR -> err_long = 1; no frame_valid. err_clr pulse then clears it, and err_clr coincident with a new short frame leaves err_short = 1.
- rst asserted mid RD_DATA frame with SS_n still low -> outputs zero; the rest of that frame is ignored; the next frame after SS_n goes high decodes normally. Also force cnt_wr to 0xFFFF and send a WR_ADDR -> counter stays 0xFFFF.
